axi4_command_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4 address channel (AR or AW) among NumPorts independent command sources. Each source presents address/length commands with a valid/ready handshake. The arbiter registers the winning command into a single-entry output stage that drives the AXI4 AX signals. An outstanding-command counter, decremented by a completion pulse from the data-channel side, caps in-flight bursts at MaxOutstanding.

---
 rtl/axi4_pkg.sv | 25 ++
 rtl/rr_priority_select.sv | 35 +++
 rtl/axi4_command_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi4_command_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and helpers for the command-channel blocks.
package axi4_pkg;

    localparam logic [1:0] AXBURST_INCR    = 2'b01;
    localparam logic [3:0] AXCACHE_DEFAULT = 4'b0010;
    localparam logic [2:0] AXPROT_DEFAULT  = 3'b000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // AXSIZE encoding: log2 of the bytes per beat for a given data width.
    function automatic logic [2:0] axsize_from_width(input int data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_width / 8)) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester above last_idx, wrapping.
module rr_priority_select #(
    parameter int NumPorts = 4,
    parameter int IdxW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req,
    input  logic [IdxW-1:0]     last_idx,
    output logic [NumPorts-1:0] onehot,
    output logic [IdxW-1:0]     idx,
    output logic                any_req
);

    int             pos;
    logic           found;
    logic [IdxW-1:0] pos_idx;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 1; k <= NumPorts; k++) begin
            pos     = (int'(last_idx) + k) % NumPorts;
            pos_idx = IdxW'(pos);
            if (!found && req[pos_idx]) begin
                found           = 1'b1;
                onehot[pos_idx] = 1'b1;
                idx             = pos_idx;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/axi4_command_arbiter.sv
// Round-robin arbiter sharing one AXI4 AR/AW channel; single-entry output stage
// plus in-flight cap. Optional AXID/CPLID ports under AXI4_CMD_ARB_ID_EN.
module axi4_command_arbiter
    import axi4_pkg::*;
#(
    parameter int NumPorts       = 4,
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 8
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [NumPorts*AddressWidth-1:0]       S_ADDR,
    input  logic [NumPorts*8-1:0]                  S_LEN,
    input  logic [NumPorts-1:0]                    S_VALID,
    output logic [NumPorts-1:0]                    S_READY,
    output logic [AddressWidth-1:0]                AXADDR,
    output logic [7:0]                             AXLEN,
    output logic [2:0]                             AXSIZE,
    output logic [1:0]                             AXBURST,
    output logic [3:0]                             AXCACHE,
    output logic [2:0]                             AXPROT,
    output logic                                   AXVALID,
    input  logic                                   AXREADY,
    input  logic                                   CPLVALID,
`ifdef AXI4_CMD_ARB_ID_EN
    output logic [$clog2(NumPorts)-1:0]            AXID,
    input  logic [$clog2(NumPorts)-1:0]            CPLID,
`endif
    output logic [NumPorts-1:0]                    GRANT,
    output logic [$clog2(MaxOutstanding+1)-1:0]    OUTSTANDING
);

    localparam int IdxW = $clog2(NumPorts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    stage_state_e          state_p1;
    logic [AddressWidth-1:0] addr_p1;
    logic [7:0]            len_p1;
    logic [NumPorts-1:0]   grant_p1;
    logic [IdxW-1:0]       last_grant;
    logic [CntW-1:0]       cnt_p1;

    logic [NumPorts-1:0]   win_onehot;
    logic [IdxW-1:0]       win_idx;
    logic                  any_req;
    logic [AddressWidth-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic                  slot_free;
    logic                  load;
    logic                  cpl_eff;

    // Accept increments, completion decrements; a completion at zero is dropped.
    function automatic logic [CntW-1:0] cnt_update(input logic [CntW-1:0] cnt,
                                                   input logic inc, input logic dec);
        logic [CntW-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

    rr_priority_select #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_select (
        .req      (S_VALID),
        .last_idx (last_grant),
        .onehot   (win_onehot),
        .idx      (win_idx),
        .any_req  (any_req)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (win_onehot[i]) begin
                sel_addr = S_ADDR[i*AddressWidth +: AddressWidth];
                sel_len  = S_LEN[i*8 +: 8];
            end
        end
    end

    // The limit uses the registered count, so a same-cycle completion frees nothing yet.
    assign slot_free = (cnt_p1 < CntW'(MaxOutstanding));
    assign load      = ((state_p1 == ST_EMPTY) || AXREADY) && slot_free && any_req;
    assign S_READY   = load ? win_onehot : '0;
    assign cpl_eff   = CPLVALID && (cnt_p1 != '0);

    // ---- output stage (p1) ----
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_p1   <= ST_EMPTY;
            addr_p1    <= '0;
            len_p1     <= '0;
            grant_p1   <= '0;
            last_grant <= IdxW'(NumPorts - 1);
            cnt_p1     <= '0;
        end else begin
            if (load) begin
                state_p1   <= ST_FULL;
                addr_p1    <= sel_addr;
                len_p1     <= sel_len;
                grant_p1   <= win_onehot;
                last_grant <= win_idx;
            end else if ((state_p1 == ST_FULL) && AXREADY) begin
                state_p1 <= ST_EMPTY;
                grant_p1 <= '0;
            end
            cnt_p1 <= cnt_update(cnt_p1, load, cpl_eff);
        end
    end

    assign AXVALID     = (state_p1 == ST_FULL);
    assign AXADDR      = addr_p1;
    assign AXLEN       = len_p1;
    assign GRANT       = grant_p1;
    assign OUTSTANDING = cnt_p1;
    assign AXSIZE      = axsize_from_width(DataWidth);
    assign AXBURST     = AXBURST_INCR;
    assign AXCACHE     = AXCACHE_DEFAULT;
    assign AXPROT      = AXPROT_DEFAULT;

`ifdef AXI4_CMD_ARB_ID_EN
    logic [IdxW-1:0] id_p1;
    logic            unused_cplid;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            id_p1 <= '0;
        end else if (load) begin
            id_p1 <= win_idx;
        end
    end

    assign AXID         = id_p1;
    // CPLID is reserved; completions are counted regardless of ID.
    assign unused_cplid = ^CPLID;
`endif

endmodule

// File: tb/tb_axi4_command_arbiter.sv
// Self-checking bench for axi4_command_arbiter: vector table, reference model
// with command scoreboard, and hand-written limit/stall/reset sequences.
module tb_axi4_command_arbiter;

    localparam int NP   = 4;
    localparam int AW   = 32;
    localparam int MAXO = 8;

    logic            ACLK;
    logic            ARESETN;
    logic [NP*AW-1:0] s_addr;
    logic [NP*8-1:0] s_len;
    logic [NP-1:0]   s_valid;
    logic [NP-1:0]   s_ready;
    logic [AW-1:0]   axaddr;
    logic [7:0]      axlen;
    logic [2:0]      axsize;
    logic [1:0]      axburst;
    logic [3:0]      axcache;
    logic [2:0]      axprot;
    logic            axvalid;
    logic            axready;
    logic            cplvalid;
    logic [NP-1:0]   grant;
    logic [3:0]      outstanding;

    logic [NP-1:0]   s_valid2;
    logic [NP-1:0]   s_ready2;
    logic            cplvalid2;
    logic            axvalid2;
    logic [1:0]      outstanding2;
    logic [AW-1:0]   axaddr2;
    logic [7:0]      axlen2;
    logic [2:0]      axsize2;
    logic [1:0]      axburst2;
    logic [3:0]      axcache2;
    logic [2:0]      axprot2;
    logic [NP-1:0]   grant2;
`ifdef AXI4_CMD_ARB_ID_EN
    logic [1:0]      axid, axid2;
    logic [1:0]      cplid;
`endif

    axi4_command_arbiter #(.NumPorts(NP), .AddressWidth(AW), .DataWidth(32), .MaxOutstanding(MAXO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .S_ADDR(s_addr), .S_LEN(s_len), .S_VALID(s_valid),
        .S_READY(s_ready), .AXADDR(axaddr), .AXLEN(axlen), .AXSIZE(axsize), .AXBURST(axburst),
        .AXCACHE(axcache), .AXPROT(axprot), .AXVALID(axvalid), .AXREADY(axready),
        .CPLVALID(cplvalid),
`ifdef AXI4_CMD_ARB_ID_EN
        .AXID(axid), .CPLID(cplid),
`endif
        .GRANT(grant), .OUTSTANDING(outstanding)
    );

    axi4_command_arbiter #(.NumPorts(NP), .AddressWidth(AW), .DataWidth(32), .MaxOutstanding(2)) dut2 (
        .ACLK(ACLK), .ARESETN(ARESETN), .S_ADDR(s_addr), .S_LEN(s_len), .S_VALID(s_valid2),
        .S_READY(s_ready2), .AXADDR(axaddr2), .AXLEN(axlen2), .AXSIZE(axsize2), .AXBURST(axburst2),
        .AXCACHE(axcache2), .AXPROT(axprot2), .AXVALID(axvalid2), .AXREADY(axready),
        .CPLVALID(cplvalid2),
`ifdef AXI4_CMD_ARB_ID_EN
        .AXID(axid2), .CPLID(cplid),
`endif
        .GRANT(grant2), .OUTSTANDING(outstanding2)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of dut (MaxOutstanding=8) and its issued-command scoreboard.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  gnt;
    } cmd_t;
    cmd_t sbq[$];

    bit          m_full;
    int          m_last, m_cnt, m_acc;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [3:0]  m_grant;

    task automatic model_reset();
        m_full = 0; m_last = NP - 1; m_cnt = 0; m_acc = -1;
        m_addr = '0; m_len = '0; m_grant = '0;
        sbq.delete();
    endtask

    task automatic cycle();
        int   win;
        bit   ld;
        logic [3:0] er;
        cmd_t c;
        @(negedge ACLK);
        win = -1;
        for (int k = 1; k <= NP; k++) begin
            if (win < 0 && s_valid[(m_last + k) % NP]) win = (m_last + k) % NP;
        end
        ld = (!m_full || axready) && (m_cnt < MAXO) && (win >= 0);
        er = ld ? 4'(1 << win) : 4'b0000;
        if (ARESETN) begin
            chk("m_s_ready", s_ready, er);
            chk("m_axvalid", axvalid, m_full);
            chk("m_grant", grant, m_grant);
            chk("m_outstanding", outstanding, m_cnt);
            if (m_full) begin
                chk("m_axaddr", axaddr, m_addr);
                chk("m_axlen", axlen, m_len);
            end
            if (axvalid && axready) begin
                chk("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    c = sbq.pop_front();
                    chk("sb_addr", axaddr, c.addr);
                    chk("sb_len", axlen, c.len);
                    chk("sb_grant", grant, c.gnt);
                end
            end
        end
        @(posedge ACLK);
        if (!ARESETN) begin
            model_reset();
        end else begin
            m_acc = -1;
            if (ld) begin
                m_addr  = s_addr[win*AW +: AW];
                m_len   = s_len[win*8 +: 8];
                m_grant = 4'(1 << win);
                m_last  = win;
                m_full  = 1;
                m_acc   = win;
                c.addr = m_addr; c.len = m_len; c.gnt = m_grant;
                sbq.push_back(c);
            end else if (m_full && axready) begin
                m_full  = 0;
                m_grant = '0;
            end
            m_cnt = m_cnt + (ld ? 1 : 0) - ((cplvalid && m_cnt > 0) ? 1 : 0);
        end
        #1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        axr;
        logic        cpl;
        logic [3:0]  rdy;
        logic        axv;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  gnt;
        logic [3:0]  outs;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h0,    8'd0,  4'b0000, 4'd0};
        tbl[1] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h1000, 8'd15, 4'b0001, 4'd1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b0, 32'h0,    8'd0,  4'b0000, 4'd1};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 32'h2000, 8'd1,  4'b0010, 4'd1};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 32'h3000, 8'd2,  4'b0100, 4'd1};
        tbl[5] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h4000, 8'd3,  4'b1000, 4'd1};
        tbl[6] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h1000, 8'd15, 4'b0001, 4'd1};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h2000, 8'd1,  4'b0010, 4'd1};
        tbl[8] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,    8'd0,  4'b0000, 4'd0};
        tbl[9] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,    8'd0,  4'b0000, 4'd0};

        ARESETN = 1'b0; s_valid = '0; s_valid2 = '0; axready = 1'b0;
        cplvalid = 1'b0; cplvalid2 = 1'b0;
`ifdef AXI4_CMD_ARB_ID_EN
        cplid = '0;
`endif
        s_addr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        s_len  = {8'd3, 8'd2, 8'd1, 8'd15};
        model_reset();
        cycle();
        cycle();
        ARESETN = 1'b1;
        #1;
        chk("rst_axvalid", axvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_axaddr", axaddr, 0);
        chk("rst_axlen", axlen, 0);
        chk("axsize", axsize, 3'd2);
        chk("axburst", axburst, 2'b01);
        chk("axcache", axcache, 4'b0010);
        chk("axprot", axprot, 3'b000);
        chk("rst_outstanding2", outstanding2, 0);

        for (int r = 0; r < 10; r++) begin
            s_valid = tbl[r].v; axready = tbl[r].axr; cplvalid = tbl[r].cpl;
            #1;
            chk($sformatf("vec%0d_s_ready", r), s_ready, tbl[r].rdy);
            chk($sformatf("vec%0d_axvalid", r), axvalid, tbl[r].axv);
            chk($sformatf("vec%0d_grant", r), grant, tbl[r].gnt);
            chk($sformatf("vec%0d_outstanding", r), outstanding, tbl[r].outs);
            if (tbl[r].axv) begin
                chk($sformatf("vec%0d_axaddr", r), axaddr, tbl[r].addr);
                chk($sformatf("vec%0d_axlen", r), axlen, tbl[r].len);
            end
            cycle();
        end

        // Stall: AXREADY low keeps the stage frozen and blocks every source.
        s_valid = 4'b0100; axready = 1'b0; cplvalid = 1'b0;
        #1;
        chk("stall_load_ready", s_ready, 4'b0100);
        cycle();
        s_valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_s_ready", s_ready, 4'b0000);
            chk("stall_axvalid", axvalid, 1);
            chk("stall_axaddr", axaddr, 32'h3000);
            chk("stall_axlen", axlen, 8'd2);
            chk("stall_grant", grant, 4'b0100);
            cycle();
        end
        axready = 1'b1;
        #1;
        chk("resume_ready", s_ready, 4'b1000);
        cycle();
        s_valid = 4'b0011;
        #1;
        chk("resume_ready2", s_ready, 4'b0001);
        cycle();

        // Reset while FULL with three in flight.
        s_valid = '0; axready = 1'b0;
        #1;
        chk("prerst_axvalid", axvalid, 1);
        chk("prerst_outstanding", outstanding, 3);
        ARESETN = 1'b0;
        cycle();
        ARESETN = 1'b1;
        #1;
        chk("midrst_axvalid", axvalid, 0);
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_grant", grant, 0);
        s_valid = 4'b1111; axready = 1'b1;
        #1;
        chk("midrst_first_ready", s_ready, 4'b0001);
        cycle();
        s_valid = '0;

        // MaxOutstanding=2 instance: cap, then one slot freed per completion.
        s_valid2 = 4'b0010;
        #1; chk("max2_a_ready", s_ready2, 4'b0010); chk("max2_a_out", outstanding2, 0); cycle();
        #1; chk("max2_b_ready", s_ready2, 4'b0010); chk("max2_b_out", outstanding2, 1); cycle();
        #1; chk("max2_c_ready", s_ready2, 4'b0000); chk("max2_c_out", outstanding2, 2); cycle();
        cplvalid2 = 1'b1;
        #1; chk("max2_d_ready", s_ready2, 4'b0000); chk("max2_d_out", outstanding2, 2); cycle();
        cplvalid2 = 1'b0;
        #1; chk("max2_e_ready", s_ready2, 4'b0010); chk("max2_e_out", outstanding2, 1); cycle();
        #1; chk("max2_f_ready", s_ready2, 4'b0000); chk("max2_f_out", outstanding2, 2); cycle();
        #1; chk("max2_g_ready", s_ready2, 4'b0000); chk("max2_g_out", outstanding2, 2); cycle();
        s_valid2 = '0;

        // Randomised traffic against the model; sources hold until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!s_valid[i] && $urandom_range(0, 2) == 0) begin
                    s_valid[i]        = 1'b1;
                    s_addr[i*AW +: AW] = $urandom;
                    s_len[i*8 +: 8]    = 8'($urandom_range(0, 255));
                end
            end
            axready  = ($urandom_range(0, 3) != 0);
            cplvalid = 1'($urandom_range(0, 1));
            cycle();
            if (m_acc >= 0) s_valid[m_acc] = 1'b0;
        end
        s_valid = '0; axready = 1'b1; cplvalid = 1'b0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
